// File: rtl/out_stage_pkg.sv
// Shared types and parameter limits for the output stage.
// Imported by the FIFO and the stage top.
package out_stage_pkg;

  typedef logic [15:0] t_data;

  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 8;
  localparam int DEPTH_MIN = 2;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/out_fifo.sv
// First-word-fall-through synchronous FIFO with
// sticky overflow; a dropped word never touches storage.
module out_fifo
  import out_stage_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // a pop frees the slot the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default: ;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/out_stage.sv
// Output stage: delay line, stall delay, FWFT FIFO
// and hold feedback towards the core.
module out_stage
  import out_stage_pkg::*;
#(
  parameter int DATA_W     = $bits(t_data),
  parameter int DELAY      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            stalled_i,
  input  logic                            dataoutv_i,
  input  logic [DATA_W-1:0]               dataout_i,
  input  logic                            out_ready_i,
  output logic                            stalled_o,
  output logic                            dataoutv_o,
  output logic [DATA_W-1:0]               dataout_o,
  output logic                            hold_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            overflow_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] HOLD_TH = CW'(FIFO_DEPTH - DELAY);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  if (DELAY < DELAY_MIN || DELAY > DELAY_MAX) begin : g_bad_delay
    $error("out_stage: DELAY outside 1..8");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < DEPTH_MIN) begin : g_bad_pow2
    $error("out_stage: FIFO_DEPTH must be a power of 2");
  end
  if (FIFO_DEPTH < DELAY + 1) begin : g_bad_depth
    $error("out_stage: FIFO_DEPTH must be >= DELAY+1");
  end

  logic              push_v;
  logic [DATA_W-1:0] push_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DELAY-1:0]  st_q;

  if (DELAY == 1) begin : g_direct
    assign push_v = dataoutv_i;
    assign push_d = dataout_i;
  end else begin : g_line
    localparam int N = DELAY - 1;
    logic [N-1:0]             v_q;
    logic [N-1:0][DATA_W-1:0] d_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        v_q <= '0;
      end else begin
        v_q[0] <= dataoutv_i;
        for (int i = 1; i < N; i++) v_q[i] <= v_q[i-1];
      end
    end

    // data bits of invalid stages are don't-care
    always_ff @(posedge clock) begin
      d_q[0] <= dataout_i;
      for (int i = 1; i < N; i++) d_q[i] <= d_q[i-1];
    end

    assign push_v = v_q[N-1];
    assign push_d = d_q[N-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q <= '0;
    end else begin
      st_q[0] <= stalled_i;
      for (int i = 1; i < DELAY; i++) st_q[i] <= st_q[i-1];
    end
  end

  assign stalled_o = st_q[DELAY-1];

  out_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_v),
    .din      (push_d),
    .pop      (out_ready_i),
    .dout     (dataout_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count_o),
    .overflow (overflow_o)
  );

  assign dataoutv_o = !fifo_empty;
  // registered count only, so in-flight words always fit
  assign hold_o = (count_o > HOLD_TH);

  always_ff @(posedge clock) begin
    if (!reset && fifo_full) assert (count_o == FULL_CNT);
  end

endmodule
